rc6_key_schedule: RTL
=====================

RC6_KEY_SCHEDULE -- requirements
Module: rc6_key_schedule

Interface
REQ-001 Parameter W, default 32, word width in bits; legal values 16, 32, 64.
REQ-002 Parameter R, default 20, cipher round count; legal range 1..255; T = 2R+4 S-table words.
REQ-003 Parameter C, default 4, key length in W-bit words; legal range 1..64.
REQ-004 inClk  input  1  sole clock; all state updates on rising edge.
REQ-005 inReset  input  1  asynchronous, active-high reset.
REQ-006 inStart  input  1  start request; sampled only in IDLE.
REQ-007 inKey  input  C*W  user key; L[j] = inKey[j*W +: W] (word 0 = least significant).
REQ-008 inRdAddr  input  clog2(T)  S-table read address.
REQ-009 outRdData  output  W  S[inRdAddr], registered, 1-cycle latency.
REQ-010 outBusy  output  1  high in INIT and MIX.
REQ-011 outDone  output  1  one-cycle pulse on schedule completion.
REQ-012 outKeyValid  output  1  high from the DONE cycle until the next accepted start or reset.

Function
REQ-013 FSM states IDLE, INIT, MIX, DONE; DONE always returns to IDLE next cycle.
REQ-014 IDLE + inStart=1: capture inKey into L[0..C-1], clear A, B, i, j; go to INIT; outKeyValid falls next cycle.
REQ-015 INIT: write S[i] = P + i*Q (mod 2^W), one word per cycle, i = 0..T-1; exactly T cycles.
REQ-016 MIX: exactly N = 3*max(T,C) cycles, one iteration per cycle; A and B start at 0; i and j restart at 0.
REQ-017 Each MIX cycle: A' = ROTL(S[i]+A+B, 3); S[i] = A'; B' = ROTL(L[j]+A'+B, (A'+B) mod W); L[j] = B'; i = (i+1) mod T; j = (j+1) mod C.
REQ-018 All additions are modulo 2^W; the rotate amount uses the low log2(W) bits only.
REQ-019 Latency: start accepted at edge k -> outDone high in cycle k+T+N+1; default parameters give 177.
REQ-020 inStart while not in IDLE is ignored; the in-progress run and its timing are unaffected.
REQ-021 inRdAddr >= T returns 0.
REQ-022 Reads while outBusy=1 return current table contents; their value is unspecified for verification.
REQ-023 The S-table is held after DONE until the next accepted start.

Reset
REQ-024 inReset=1 forces IDLE immediately; outBusy, outDone, outKeyValid, and outRdData = 0; A, B, i, j = 0.
REQ-025 Reset mid-INIT or mid-MIX aborts the run; S and L contents are don't-care until the next full run.

Structure
REQ-026 Shared package rc6_pkg holds the P/Q constants per W: 16: B7E1/9E37; 32: B7E15163/9E3779B9; 64: B7E151628AED2A6B/9E3779B97F4A7C15.
REQ-027 rc6_pkg also holds the FSM state enum and a max() helper for N.
REQ-028 One sub-module, rc6_rotl_w (parameter W): combinational left rotate by a log2(W)-bit amount, instantiated twice (constant 3 and dynamic).
REQ-029 S is a T-entry register/RAM array; L is a C-entry register array.

Verification
REQ-030 Reset: assert inReset asynchronously mid-cycle -> all outputs 0 before the next edge; state IDLE.
REQ-031 W=32/R=20/C=4, key all-zero -> outDone exactly 177 cycles after start; all 44 S words match the software model; fed to the encryptor, plaintext 0 gives 8fc3a536 56b1f778 c129df4e 9848a41e.
REQ-032 Pulse inStart every cycle while busy -> ignored; single outDone at cycle 177; outKeyValid then high.
REQ-033 inReset during MIX at cycle 100, then restart -> outKeyValid 0; new outDone 177 cycles after the restart; S matches the model.
REQ-034 W=16/R=2/C=16 (C>T: T=8, N=48) -> outDone at cycle 57; S matches the model; W=64/R=20/C=4 -> done at 177.
REQ-035 After done, read inRdAddr=0 and 43 -> model values one cycle later; inRdAddr=50 (out of range) -> 0.

Source files
------------

// File: rtl/rc6_pkg.sv
// RC6 key-schedule shared types and constants: FSM states, magic P/Q per word width, max helper.
package rc6_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_MIX,
        ST_DONE
    } rc6_state_t;

    // Magic constants, zero-extended to 64 bits; callers truncate to W.
    function automatic logic [63:0] rc6_p(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_B7E1;
            64:      return 64'hB7E1_5162_8AED_2A6B;
            default: return 64'h0000_0000_B7E1_5163;
        endcase
    endfunction

    function automatic logic [63:0] rc6_q(input int w);
        case (w)
            16:      return 64'h0000_0000_0000_9E37;
            64:      return 64'h9E37_79B9_7F4A_7C15;
            default: return 64'h0000_0000_9E37_79B9;
        endcase
    endfunction

    function automatic int rc6_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rc6_rotl_w.sv
// W-bit left rotate by a log2(W)-bit amount.
// Latency: combinational; backpressure: none.
module rc6_rotl_w #(
    parameter int W = 32
) (
    input  logic [W-1:0]         din,
    input  logic [$clog2(W)-1:0] amt,
    output logic [W-1:0]         dout
);

    logic [2*W-1:0] dbl;

    assign dbl  = {din, din} << amt;
    assign dout = dbl[2*W-1:W];

endmodule

// File: rtl/rc6_key_schedule.sv
// RC6 key expansion into a 2R+4 word S-table, readable through a registered port.
// Latency: T+N+1 cycles start-to-done, read data 1 cycle; backpressure: none, start ignored while busy.
module rc6_key_schedule
    import rc6_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 20,
    parameter int C = 4
) (
    input  logic                        inClk,
    input  logic                        inReset,
    input  logic                        inStart,
    input  logic [C*W-1:0]              inKey,
    input  logic [$clog2(2*R+4)-1:0]    inRdAddr,
    output logic [W-1:0]                outRdData,
    output logic                        outBusy,
    output logic                        outDone,
    output logic                        outKeyValid
);

    localparam int T  = 2*R + 4;
    localparam int AW = $clog2(T);
    localparam int N  = 3 * rc6_max(T, C);
    localparam int CW = $clog2(N);
    localparam int LW = $clog2(W);
    localparam int JW = (C > 1) ? $clog2(C) : 1;

    localparam logic [W-1:0]  P_W    = W'(rc6_p(W));
    localparam logic [W-1:0]  Q_W    = W'(rc6_q(W));
    localparam logic [AW-1:0] I_LAST = AW'(T - 1);
    localparam logic [JW-1:0] J_LAST = JW'(C - 1);
    localparam logic [CW-1:0] N_LAST = CW'(N - 1);
    localparam logic [AW:0]   T_EXT  = (AW+1)'(T);
    localparam logic [LW-1:0] ROT3   = LW'(3);

    rc6_state_t state, state_nxt;

    logic [W-1:0]  s_tab [T];
    logic [W-1:0]  l_tab [C];
    logic [W-1:0]  a_reg, b_reg, init_val;
    logic [AW-1:0] i_idx;
    logic [JW-1:0] j_idx;
    logic [CW-1:0] mix_cnt;
    logic          key_vld;

    logic [W-1:0]  a_sum, a_new, b_sum, b_new;
    logic [LW-1:0] b_amt;

    // One mixing iteration; both rotates settle within the cycle.
    assign a_sum = s_tab[i_idx] + a_reg + b_reg;
    assign b_sum = l_tab[j_idx] + a_new + b_reg;
    assign b_amt = LW'(a_new + b_reg);

    rc6_rotl_w #(.W(W)) u_rotl_a (.din(a_sum), .amt(ROT3),  .dout(a_new));
    rc6_rotl_w #(.W(W)) u_rotl_b (.din(b_sum), .amt(b_amt), .dout(b_new));

    always_comb begin
        state_nxt = state;
        outBusy   = 1'b0;
        outDone   = 1'b0;
        case (state)
            ST_IDLE: if (inStart) state_nxt = ST_INIT;
            ST_INIT: begin
                outBusy = 1'b1;
                if (i_idx == I_LAST) state_nxt = ST_MIX;
            end
            ST_MIX: begin
                outBusy = 1'b1;
                if (mix_cnt == N_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                outDone   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            mix_cnt  <= '0;
            init_val <= '0;
            key_vld  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (inStart) begin
                    a_reg    <= '0;
                    b_reg    <= '0;
                    i_idx    <= '0;
                    j_idx    <= '0;
                    mix_cnt  <= '0;
                    init_val <= P_W;
                    key_vld  <= 1'b0;
                end
                ST_INIT: begin
                    init_val <= init_val + Q_W;
                    i_idx    <= (i_idx == I_LAST) ? '0 : i_idx + 1'b1;
                end
                ST_MIX: begin
                    a_reg   <= a_new;
                    b_reg   <= b_new;
                    i_idx   <= (i_idx == I_LAST) ? '0 : i_idx + 1'b1;
                    j_idx   <= (j_idx == J_LAST) ? '0 : j_idx + 1'b1;
                    mix_cnt <= mix_cnt + 1'b1;
                    if (mix_cnt == N_LAST) key_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Table storage carries no reset; an aborted run leaves it undefined until the next full run.
    always_ff @(posedge inClk) begin
        if (state == ST_IDLE && inStart) begin
            for (int k = 0; k < C; k++) l_tab[k] <= inKey[k*W +: W];
        end
        if (state == ST_INIT) s_tab[i_idx] <= init_val;
        if (state == ST_MIX) begin
            s_tab[i_idx] <= a_new;
            l_tab[j_idx] <= b_new;
        end
    end

    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset)                     outRdData <= '0;
        else if ({1'b0, inRdAddr} < T_EXT) outRdData <= s_tab[inRdAddr];
        else                             outRdData <= '0;
    end

    assign outKeyValid = key_vld;

endmodule
